// File: rtl/mem_stream_reader_if.sv
// Bundle of command, memory-read and output-stream signals for mem_stream_reader.
// The master modport is the reader's view; slave is the surrounding environment.
interface mem_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10
) ();
    logic [ADDR_WIDTH-1:0] cmdAddrIn;
    logic [LEN_WIDTH-1:0]  cmdLenIn;
    logic                  cmdValidIn;
    logic                  cmdReadyOut;
    logic [ADDR_WIDTH-1:0] memAddrOut;
    logic                  memRdEnOut;
    logic [DATA_WIDTH-1:0] memDataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  validOut;
    logic                  readyIn;
    logic                  lastOut;
    logic                  busyOut;
    logic                  doneOut;

    modport master (
        input  cmdAddrIn, cmdLenIn, cmdValidIn, memDataIn, readyIn,
        output cmdReadyOut, memAddrOut, memRdEnOut, dataOut, validOut,
        output lastOut, busyOut, doneOut
    );

    modport slave (
        output cmdAddrIn, cmdLenIn, cmdValidIn, memDataIn, readyIn,
        input  cmdReadyOut, memAddrOut, memRdEnOut, dataOut, validOut,
        input  lastOut, busyOut, doneOut
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Command-driven sequential RAM reader that streams words on valid/ready,
// absorbing backpressure in a 2-entry register buffer.
module mem_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10
) (
    input  logic               clkIn,
    input  logic               rstIn,
    mem_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                stateR;
    logic [ADDR_WIDTH-1:0] rdPtrR;
    logic [LEN_WIDTH-1:0]  issueRemR;
    logic [LEN_WIDTH-1:0]  beatRemR;
    logic                  inflightR;
    logic                  cmdReadyR;
    logic                  busyR;
    logic                  doneR;
    logic [1:0]            bufCountR;
    logic [DATA_WIDTH-1:0] buf0R;
    logic [DATA_WIDTH-1:0] buf1R;

    logic                  popS;
    logic                  issueS;
    logic                  finishS;
    logic [1:0]            occS;

    // Issue/pop/finish decisions; issue sees the same-cycle pop so a freed slot refills at once.
    always_comb begin
        popS    = 1'b0;
        issueS  = 1'b0;
        finishS = 1'b0;
        occS    = bufCountR + {1'b0, inflightR};
        if (bufCountR != 2'd0) begin
            popS = bus.readyIn;
        end else begin
            popS = 1'b0;
        end
        if ((stateR == RUN) && (issueRemR != {LEN_WIDTH{1'b0}}) &&
            ({1'b0, occS} < (3'd2 + {2'b00, popS}))) begin
            issueS = 1'b1;
        end else begin
            issueS = 1'b0;
        end
        if ((stateR == DRAIN) && !inflightR &&
            ((beatRemR == {LEN_WIDTH{1'b0}}) ||
             ((beatRemR == LEN_WIDTH'(1)) && popS))) begin
            finishS = 1'b1;
        end else begin
            finishS = 1'b0;
        end
    end

    // Control FSM with its registered status outputs and counters.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            stateR    <= IDLE;
            rdPtrR    <= {ADDR_WIDTH{1'b0}};
            issueRemR <= {LEN_WIDTH{1'b0}};
            beatRemR  <= {LEN_WIDTH{1'b0}};
            inflightR <= 1'b0;
            cmdReadyR <= 1'b1;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
        end else begin
            doneR     <= 1'b0;
            inflightR <= issueS;
            if (popS) begin
                beatRemR <= beatRemR - LEN_WIDTH'(1);
            end
            case (stateR)
                IDLE: begin
                    if (bus.cmdValidIn) begin
                        rdPtrR    <= bus.cmdAddrIn;
                        issueRemR <= bus.cmdLenIn;
                        beatRemR  <= bus.cmdLenIn;
                        cmdReadyR <= 1'b0;
                        busyR     <= 1'b1;
                        stateR    <= (bus.cmdLenIn != {LEN_WIDTH{1'b0}}) ? RUN : DRAIN;
                    end else begin
                        busyR <= 1'b0;
                    end
                end
                RUN: begin
                    if (issueS) begin
                        rdPtrR    <= rdPtrR + ADDR_WIDTH'(1);
                        issueRemR <= issueRemR - LEN_WIDTH'(1);
                        if (issueRemR == LEN_WIDTH'(1)) begin
                            stateR <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // busyR stays high through the done cycle, which is already IDLE.
                    if (finishS) begin
                        stateR    <= IDLE;
                        doneR     <= 1'b1;
                        cmdReadyR <= 1'b1;
                    end
                end
                default: begin
                    stateR    <= IDLE;
                    cmdReadyR <= 1'b1;
                    busyR     <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry FIFO fed by returning read data; buf0R is always the head.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            bufCountR <= 2'd0;
            buf0R     <= {DATA_WIDTH{1'b0}};
            buf1R     <= {DATA_WIDTH{1'b0}};
        end else begin
            case ({inflightR, popS})
                2'b10: begin
                    if (bufCountR == 2'd0) begin
                        buf0R <= bus.memDataIn;
                    end else begin
                        buf1R <= bus.memDataIn;
                    end
                    bufCountR <= bufCountR + 2'd1;
                end
                2'b01: begin
                    buf0R     <= buf1R;
                    bufCountR <= bufCountR - 2'd1;
                end
                2'b11: begin
                    if (bufCountR == 2'd1) begin
                        buf0R <= bus.memDataIn;
                    end else begin
                        buf0R <= buf1R;
                        buf1R <= bus.memDataIn;
                    end
                end
                default: begin
                    bufCountR <= bufCountR;
                end
            endcase
        end
    end

    assign bus.cmdReadyOut = cmdReadyR;
    assign bus.memAddrOut  = rdPtrR;
    assign bus.memRdEnOut  = issueS;
    assign bus.dataOut     = buf0R;
    assign bus.validOut    = (bufCountR != 2'd0);
    assign bus.lastOut     = (bufCountR != 2'd0) && (beatRemR == LEN_WIDTH'(1));
    assign bus.busyOut     = busyR;
    assign bus.doneOut     = doneR;
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a RAM model and an expected-beat scoreboard.
module tb_mem_stream_reader;
    logic clkIn = 1'b0;
    logic rstIn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t      expQ[$];
    logic [8:0] addrQ[$];
    int         outst = 0;
    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic       prevLast = 1'b0;
    logic [31:0] prevData = 32'd0;
    logic [31:0] ram [512];

    always #5 clkIn = ~clkIn;

    mem_stream_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .LEN_WIDTH(10)) bus ();

    mem_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .LEN_WIDTH(10)) dut (
        .clkIn(clkIn),
        .rstIn(rstIn),
        .bus  (bus.master)
    );

    // Synchronous RAM, one-cycle read latency
    always @(posedge clkIn) begin
        if (bus.memRdEnOut) bus.memDataIn <= ram[bus.memAddrOut];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectCmd(input int addr, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            logic [8:0] a;
            a = 9'((addr + i) % 512);
            b.data = 32'(int'(a) * 3);
            b.last = (i == len - 1);
            expQ.push_back(b);
            addrQ.push_back(a);
        end
    endtask

    // Starts at posedge+1, returns at posedge+1 of cycle 1 (cycle 0 = handshake)
    task automatic send(input int addr, input int len);
        int n;
        logic ok;
        expectCmd(addr, len);
        bus.cmdAddrIn  = 9'(addr);
        bus.cmdLenIn   = 10'(len);
        bus.cmdValidIn = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clkIn);
            if (bus.cmdReadyOut) ok = 1'b1;
            else begin @(posedge clkIn); #1; end
            n++;
        end
        chk("cmdAccepted", ok, 1'b1);
        @(posedge clkIn); #1;
        bus.cmdValidIn = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int bound);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < bound) begin
            @(negedge clkIn);
            if (bus.doneOut) found = 1'b1;
            n++;
        end
        chk(tag, found, 1'b1);
        @(posedge clkIn); #1;
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_cmdReady"}, bus.cmdReadyOut, 1'b1);
        chk({tag, "_memRdEn"},  bus.memRdEnOut, 1'b0);
        chk({tag, "_memAddr"},  bus.memAddrOut, 9'd0);
        chk({tag, "_valid"},    bus.validOut, 1'b0);
        chk({tag, "_data"},     bus.dataOut, 32'd0);
        chk({tag, "_last"},     bus.lastOut, 1'b0);
        chk({tag, "_busy"},     bus.busyOut, 1'b0);
        chk({tag, "_done"},     bus.doneOut, 1'b0);
    endtask

    // Output monitor: scoreboard, address order, occupancy bound and hold-under-stall
    always @(negedge clkIn) begin
        logic popN;
        if (rstIn) begin
            outst = 0;
            prevValid = 1'b0;
        end else begin
            popN = bus.validOut && bus.readyIn;
            if (prevValid && !prevReady) begin
                chk("holdValid", bus.validOut, 1'b1);
                chk("holdData", bus.dataOut, prevData);
                chk("holdLast", bus.lastOut, prevLast);
            end
            if (bus.memRdEnOut) begin
                chk("issueWhileFull", ((outst - int'(popN)) < 2), 1'b1);
                chk("addrExpected", (addrQ.size() > 0), 1'b1);
                if (addrQ.size() > 0) chk("memAddr", bus.memAddrOut, addrQ.pop_front());
            end
            if (popN) begin
                chk("beatExpected", (expQ.size() > 0), 1'b1);
                if (expQ.size() > 0) begin
                    beat_t b;
                    b = expQ.pop_front();
                    chk("beatData", bus.dataOut, b.data);
                    chk("beatLast", bus.lastOut, b.last);
                end
            end
            outst = outst + int'(bus.memRdEnOut) - int'(popN);
            prevValid = bus.validOut;
            prevReady = bus.readyIn;
            prevData  = bus.dataOut;
            prevLast  = bus.lastOut;
        end
    end

    initial begin
        logic found;
        for (int a = 0; a < 512; a++) ram[a] = 32'(a * 3);
        bus.cmdAddrIn  = 9'd0;
        bus.cmdLenIn   = 10'd0;
        bus.cmdValidIn = 1'b0;
        bus.readyIn    = 1'b1;
        bus.memDataIn  = 32'd0;

        // Reset state
        repeat (2) @(negedge clkIn);
        checkResetState("rst");
        @(posedge clkIn); #1;
        rstIn = 1'b0;

        // Basic: addr 0x010, len 4
        send(16, 4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clkIn);
            chk($sformatf("basicValid_c%0d", c), bus.validOut, (c >= 3 && c <= 6));
            chk($sformatf("basicLast_c%0d", c), bus.lastOut, (c == 6));
            chk($sformatf("basicDone_c%0d", c), bus.doneOut, (c == 7));
            chk($sformatf("basicRdEn_c%0d", c), bus.memRdEnOut, (c >= 1 && c <= 4));
            chk($sformatf("basicBusy_c%0d", c), bus.busyOut, (c <= 7));
            @(posedge clkIn); #1;
        end
        chk("basicDrained", expQ.size(), 0);

        // Backpressure: len 8, random ready
        send(64, 8);
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            bus.readyIn = 1'($urandom_range(1, 0));
            @(negedge clkIn);
            if (bus.doneOut) found = 1'b1;
            @(posedge clkIn); #1;
        end
        chk("bpDone", found, 1'b1);
        bus.readyIn = 1'b1;
        chk("bpDrained", expQ.size(), 0);
        chk("bpAddrDrained", addrQ.size(), 0);

        // Zero length
        send(32, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clkIn);
            chk($sformatf("zeroRdEn_c%0d", c), bus.memRdEnOut, 1'b0);
            chk($sformatf("zeroValid_c%0d", c), bus.validOut, 1'b0);
            chk($sformatf("zeroDone_c%0d", c), bus.doneOut, (c == 2));
            chk($sformatf("zeroReady_c%0d", c), bus.cmdReadyOut, (c >= 2));
            chk($sformatf("zeroBusy_c%0d", c), bus.busyOut, (c <= 2));
            @(posedge clkIn); #1;
        end

        // Address wrap: 510, 511, 0, 1
        send(510, 4);
        waitDone("wrapDone", 30);
        chk("wrapDrained", expQ.size(), 0);
        chk("wrapAddrDrained", addrQ.size(), 0);

        // Back-to-back: second command held valid, accepted in first doneOut cycle
        expectCmd(256, 3);
        expectCmd(384, 2);
        bus.cmdAddrIn  = 9'd256;
        bus.cmdLenIn   = 10'd3;
        bus.cmdValidIn = 1'b1;
        @(negedge clkIn);
        chk("b2bReady_c0", bus.cmdReadyOut, 1'b1);
        @(posedge clkIn); #1;
        bus.cmdAddrIn = 9'd384;
        bus.cmdLenIn  = 10'd2;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clkIn);
            chk($sformatf("b2bValid_c%0d", c), bus.validOut, ((c >= 3 && c <= 5) || (c >= 9 && c <= 10)));
            chk($sformatf("b2bLast_c%0d", c), bus.lastOut, (c == 5 || c == 10));
            chk($sformatf("b2bDone_c%0d", c), bus.doneOut, (c == 6 || c == 11));
            chk($sformatf("b2bReady_c%0d", c), bus.cmdReadyOut, (c == 6 || c >= 11));
            chk($sformatf("b2bRdEn_c%0d", c), bus.memRdEnOut, ((c >= 1 && c <= 3) || (c >= 7 && c <= 8)));
            @(posedge clkIn); #1;
            if (c == 6) bus.cmdValidIn = 1'b0;
        end
        chk("b2bDrained", expQ.size(), 0);

        // Async reset during beat 3 of 8
        send(96, 8);
        repeat (4) begin @(posedge clkIn); #1; end
        #1;
        rstIn = 1'b1;
        #1;
        checkResetState("midRst");
        expQ.delete();
        addrQ.delete();
        @(posedge clkIn); @(posedge clkIn); #1;
        checkResetState("heldRst");
        rstIn = 1'b0;
        send(0, 2);
        waitDone("postRstDone", 30);
        chk("postRstDrained", expQ.size(), 0);
        chk("postRstAddrDrained", addrQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
